// File: rtl/him_event_loader_pkg.sv
// Shared widths, FSM state encoding and the hit-word mask helper for the HIMPP event loader.
package him_event_loader_pkg;

  localparam int NROWS_HIM        = 16;
  localparam int ROWINDEXBITS_HIM = 4;
  localparam int HITINFOBITS      = 8;
  localparam int MAXHITS          = 4;
  localparam int MAXHITNBITS      = 3;
  localparam int HIM_RD_LATENCY   = 4;
  localparam int DRAIN_CYCLES     = 6;
  localparam int OUTFIFO_DEPTH    = 8;

  localparam int NCOLS_HIM   = MAXHITS * HITINFOBITS;
  localparam int TAGBITS     = ROWINDEXBITS_HIM + MAXHITNBITS;
  localparam int FIFOBITS    = TAGBITS + NCOLS_HIM;
  localparam int FIFOCNTBITS = $clog2(OUTFIFO_DEPTH + 1);
  localparam int DRAINBITS   = $clog2(DRAIN_CYCLES + 1);

  typedef enum logic [2:0] {
    ST_FILL,
    ST_DRAIN,
    ST_SCAN,
    ST_FINISH,
    ST_CLEAR
  } state_e;

  // Keeps only the hit slots below nhits; anything above is stale HIM content.
  function automatic logic [NCOLS_HIM-1:0] hit_mask(input logic [MAXHITNBITS-1:0] nhits);
    logic [NCOLS_HIM-1:0] m;
    m = '0;
    for (int unsigned k = 0; k < MAXHITS; k++) begin
      if (k < 32'(nhits)) m[k*HITINFOBITS +: HITINFOBITS] = '1;
    end
    return m;
  endfunction

endpackage

// File: rtl/him_event_loader_rd_fifo.sv
// Synchronous FIFO holding {row, nhits, masked hit word} beats for the readout stream.
module him_rd_fifo
  import him_event_loader_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8,
  localparam int unsigned AW = $clog2(DEPTH),
  localparam int unsigned CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             full, do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(DEPTH));
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem_q[rd_ptr_q];
  assign count   = count_q;

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= (wr_ptr_q == AW'(DEPTH - 1)) ? '0 : wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= (rd_ptr_q == AW'(DEPTH - 1)) ? '0 : rd_ptr_q + AW'(1);
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/him_event_loader.sv
// HIMPP requester: counts hits per row while filling, then scans rows and streams back masked hit words.
module him_event_loader
  import him_event_loader_pkg::*;
(
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        hit_valid,
  output logic                        hit_ready,
  input  logic [ROWINDEXBITS_HIM-1:0] hit_row,
  input  logic [HITINFOBITS-1:0]      hit_info,
  input  logic                        flush,
  input  logic                        him_ready,
  output logic                        writeRow,
  output logic [ROWINDEXBITS_HIM-1:0] inputRowToWrite,
  output logic [NCOLS_HIM-1:0]        inputHitInfo,
  output logic [MAXHITNBITS-1:0]      nOldHits,
  output logic [MAXHITNBITS-1:0]      nNewHits,
  output logic                        readRow,
  output logic [ROWINDEXBITS_HIM-1:0] inputRowToRead,
  input  logic [NCOLS_HIM-1:0]        hitInfo_read,
  output logic                        rd_valid,
  input  logic                        rd_ready,
  output logic [ROWINDEXBITS_HIM-1:0] rd_row,
  output logic [MAXHITNBITS-1:0]      rd_nhits,
  output logic [NCOLS_HIM-1:0]        rd_data,
  output logic                        overflow,
  output logic                        done
);

  state_e                        state_q, state_d;
  logic [ROWINDEXBITS_HIM-1:0]   ptr_q, ptr_d;
  logic [DRAINBITS-1:0]          dcnt_q, dcnt_d;
  logic [MAXHITNBITS-1:0]        cnt_q [NROWS_HIM];
  logic                          overflow_q;
  logic                          wr_q, rd_q;
  logic [ROWINDEXBITS_HIM-1:0]   wrow_q, rrow_q;
  logic [NCOLS_HIM-1:0]          winfo_q;
  logic [MAXHITNBITS-1:0]        nold_q, nnew_q;
  logic [HIM_RD_LATENCY:0]       vld_q;
  logic [TAGBITS-1:0]            tag_q [HIM_RD_LATENCY+1];

  logic                          accept, issue, step, credit_ok;
  logic [FIFOCNTBITS:0]          occ;
  logic [FIFOBITS-1:0]           fifo_din, fifo_dout;
  logic                          fifo_empty;
  logic [FIFOCNTBITS-1:0]        fifo_count;
  logic [TAGBITS-1:0]            tag_out;

  // Reads in flight (tag pipe) plus FIFO occupancy must stay below depth so every return has a slot.
  always_comb begin
    occ = {1'b0, fifo_count};
    for (int unsigned i = 0; i <= HIM_RD_LATENCY; i++) occ = occ + (FIFOCNTBITS+1)'(vld_q[i]);
    credit_ok = occ < (FIFOCNTBITS+1)'(OUTFIFO_DEPTH);
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    dcnt_d    = dcnt_q;
    hit_ready = 1'b0;
    issue     = 1'b0;
    step      = 1'b0;
    case (state_q)
      ST_FILL: begin
        hit_ready = him_ready;
        dcnt_d    = '0;
        if (flush) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (dcnt_q != DRAINBITS'(DRAIN_CYCLES)) dcnt_d = dcnt_q + 1'b1;
        else if (him_ready) begin
          state_d = ST_SCAN;
          ptr_d   = '0;
        end
      end
      ST_SCAN: begin
        if (cnt_q[ptr_q] == '0) step = 1'b1;
        else if (credit_ok) begin
          issue = 1'b1;
          step  = 1'b1;
        end
        if (step) begin
          if (ptr_q == ROWINDEXBITS_HIM'(NROWS_HIM - 1)) state_d = ST_FINISH;
          else ptr_d = ptr_q + 1'b1;
        end
      end
      ST_FINISH: if (vld_q == '0 && fifo_empty) state_d = ST_CLEAR;
      ST_CLEAR:  state_d = ST_FILL;
      default:   state_d = ST_FILL;
    endcase
  end

  assign accept = hit_valid && hit_ready;
  assign done   = (state_q == ST_CLEAR);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_FILL;
      ptr_q   <= '0;
      dcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      dcnt_q  <= dcnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned r = 0; r < NROWS_HIM; r++) cnt_q[r] <= '0;
      overflow_q <= 1'b0;
      wr_q       <= 1'b0;
      rd_q       <= 1'b0;
      wrow_q     <= '0;
      rrow_q     <= '0;
      winfo_q    <= '0;
      nold_q     <= '0;
      nnew_q     <= '0;
      vld_q      <= '0;
    end else begin
      wr_q   <= 1'b0;
      nnew_q <= '0;
      rd_q   <= issue;
      vld_q  <= {vld_q[HIM_RD_LATENCY-1:0], issue};
      if (accept) begin
        if (cnt_q[hit_row] != MAXHITNBITS'(MAXHITS)) begin
          wr_q           <= 1'b1;
          wrow_q         <= hit_row;
          winfo_q        <= NCOLS_HIM'(hit_info);
          nold_q         <= cnt_q[hit_row];
          nnew_q         <= MAXHITNBITS'(1);
          cnt_q[hit_row] <= cnt_q[hit_row] + 1'b1;
        end else begin
          overflow_q <= 1'b1;
        end
      end
      if (issue) rrow_q <= ptr_q;
      if (done) begin
        for (int unsigned r = 0; r < NROWS_HIM; r++) cnt_q[r] <= '0;
        overflow_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    tag_q[0] <= {ptr_q, cnt_q[ptr_q]};
    for (int unsigned i = 1; i <= HIM_RD_LATENCY; i++) tag_q[i] <= tag_q[i-1];
  end

  assign tag_out  = tag_q[HIM_RD_LATENCY];
  assign fifo_din = {tag_out, hitInfo_read & hit_mask(tag_out[MAXHITNBITS-1:0])};

  him_rd_fifo #(
    .WIDTH (FIFOBITS),
    .DEPTH (OUTFIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (vld_q[HIM_RD_LATENCY]),
    .din   (fifo_din),
    .pop   (rd_valid && rd_ready),
    .dout  (fifo_dout),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign rd_valid        = !fifo_empty;
  assign rd_row          = rd_valid ? fifo_dout[FIFOBITS-1 -: ROWINDEXBITS_HIM] : '0;
  assign rd_nhits        = rd_valid ? fifo_dout[NCOLS_HIM +: MAXHITNBITS] : '0;
  assign rd_data         = rd_valid ? fifo_dout[NCOLS_HIM-1:0] : '0;
  assign writeRow        = wr_q;
  assign inputRowToWrite = wrow_q;
  assign inputHitInfo    = winfo_q;
  assign nOldHits        = nold_q;
  assign nNewHits        = nnew_q;
  assign readRow         = rd_q;
  assign inputRowToRead  = rrow_q;
  assign overflow        = overflow_q;

endmodule

// File: tb/tb_him_event_loader.sv
// Bench for him_event_loader: HIMPP memory model with fixed read latency and a per-row hit-list reference model.
`timescale 1ns/1ps
module tb_him_event_loader;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        hit_valid = 1'b0, hit_ready;
  logic [3:0]  hit_row = '0;
  logic [7:0]  hit_info = '0;
  logic        flush = 1'b0, him_ready = 1'b1;
  logic        writeRow, readRow;
  logic [3:0]  inputRowToWrite, inputRowToRead;
  logic [31:0] inputHitInfo;
  logic [2:0]  nOldHits, nNewHits;
  logic [31:0] hitInfo_read = '0;
  logic        rd_valid, rd_ready = 1'b1;
  logic [3:0]  rd_row;
  logic [2:0]  rd_nhits;
  logic [31:0] rd_data;
  logic        overflow, done;

  him_event_loader dut (
    .clk(clk), .reset(reset), .hit_valid(hit_valid), .hit_ready(hit_ready),
    .hit_row(hit_row), .hit_info(hit_info), .flush(flush), .him_ready(him_ready),
    .writeRow(writeRow), .inputRowToWrite(inputRowToWrite), .inputHitInfo(inputHitInfo),
    .nOldHits(nOldHits), .nNewHits(nNewHits), .readRow(readRow), .inputRowToRead(inputRowToRead),
    .hitInfo_read(hitInfo_read), .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_row(rd_row),
    .rd_nhits(rd_nhits), .rd_data(rd_data), .overflow(overflow), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [3:0] row; logic [2:0] nold; logic [7:0] info; } wr_t;
  typedef struct packed { logic [3:0] row; logic [2:0] n; logic [31:0] data; } rd_t;

  int total = 0, bad = 0;
  int rr_cnt = 0, done_cnt = 0, rd_mode = 1;
  wr_t wr_got[$], exp_wr[$];
  rd_t rd_got[$], exp_rd[$];
  logic [31:0] mem [16];
  logic [31:0] dl [4];
  int hq_row[$];
  logic [7:0] hq_info[$];

  // Reference: each row is a list of at most four hits, in arrival order.
  int unsigned m_n [16];
  logic [7:0]  m_info [16][4];
  bit          m_ovf;

  function automatic void m_clear();
    for (int r = 0; r < 16; r++) m_n[r] = 0;
    m_ovf = 0;
    exp_wr.delete();
  endfunction

  function automatic void m_hit(int row, logic [7:0] info);
    if (m_n[row] == 4) m_ovf = 1;
    else begin
      exp_wr.push_back({4'(row), 3'(m_n[row]), info});
      m_info[row][m_n[row]] = info;
      m_n[row]++;
    end
  endfunction

  function automatic void m_readout();
    logic [31:0] d;
    exp_rd.delete();
    for (int r = 0; r < 16; r++) if (m_n[r] != 0) begin
      d = '0;
      for (int k = 0; k < int'(m_n[r]); k++) d[k*8 +: 8] = m_info[r][k];
      exp_rd.push_back({4'(r), 3'(m_n[r]), d});
    end
  endfunction

  // HIMPP model: slot-addressed writes, reads return four cycles after readRow.
  always @(negedge clk) begin
    if (writeRow === 1'b1) begin
      wr_got.push_back({inputRowToWrite, nOldHits, inputHitInfo[7:0]});
      if (nOldHits < 3'd4) mem[inputRowToWrite][int'(nOldHits)*8 +: 8] = inputHitInfo[7:0];
      total++;
      if (nNewHits !== 3'd1 || inputHitInfo[31:8] !== 24'd0) begin
        bad++;
        $display("FAIL wr_fields: nNewHits=%0d upper=%h, want 1 and 0", nNewHits, inputHitInfo[31:8]);
      end
    end
    if (readRow === 1'b1) rr_cnt++;
    hitInfo_read = dl[3];
    dl[3] = dl[2];
    dl[2] = dl[1];
    dl[1] = dl[0];
    dl[0] = (readRow === 1'b1) ? mem[inputRowToRead] : $urandom;
    if (rd_valid === 1'b1 && rd_ready === 1'b1) rd_got.push_back({rd_row, rd_nhits, rd_data});
    if (done === 1'b1) done_cnt++;
  end

  always @(posedge clk) begin
    #1;
    case (rd_mode)
      0: rd_ready = 1'b0;
      1: rd_ready = 1'b1;
      default: rd_ready = ($urandom_range(0, 3) != 0);
    endcase
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic start_event();
    wr_got.delete(); rd_got.delete(); rr_cnt = 0; m_clear();
  endtask

  task automatic add_hit(input int row, input logic [7:0] info);
    hq_row.push_back(row); hq_info.push_back(info);
  endtask

  task automatic send_hits(input bit flush_last);
    for (int i = 0; i < hq_row.size(); i++) begin
      tick(1);
      hit_valid = 1'b1; hit_row = 4'(hq_row[i]); hit_info = hq_info[i];
      flush = flush_last && (i == hq_row.size() - 1);
      @(negedge clk);
      total++;
      if (hit_ready !== 1'b1) begin bad++; $display("FAIL hit_ready: got %b want 1", hit_ready); end
      m_hit(hq_row[i], hq_info[i]);
    end
    tick(1);
    hit_valid = 1'b0; flush = 1'b0;
    hq_row.delete(); hq_info.delete();
  endtask

  task automatic do_flush();
    tick(1); flush = 1'b1;
    tick(1); flush = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    int d0;
    d0 = done_cnt; ok = 0;
    for (int c = 0; c < budget; c++) begin
      @(posedge clk);
      if (done_cnt != d0) begin ok = 1; break; end
    end
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(3);
    @(negedge clk);
    total++;
    if ({writeRow, readRow, rd_valid, done, overflow, inputRowToWrite, inputRowToRead, inputHitInfo,
         nOldHits, nNewHits, rd_row, rd_nhits, rd_data} !== '0) begin
      bad++; $display("FAIL reset_outputs: some output nonzero (wr=%b rr=%b rv=%b dn=%b ov=%b), want all 0",
                      writeRow, readRow, rd_valid, done, overflow);
    end
    tick(1); reset = 1'b0;
    @(negedge clk);
    total++;
    if (hit_ready !== 1'b1) begin bad++; $display("FAIL reset_hit_ready: got %b want 1", hit_ready); end
  endtask

  task automatic test_same_row();
    bit ok;
    start_event();
    add_hit(3, 8'hA1); add_hit(3, 8'hA2); add_hit(3, 8'hA3);
    send_hits(0); do_flush(); m_readout();
    wait_done(300, ok);
    total++; if (!ok) begin bad++; $display("FAIL same_row_done: no done within 300 cycles, want done"); end
    total++; if (wr_got.size() != 3) begin bad++; $display("FAIL same_row_nwr: got %0d want 3", wr_got.size()); end
    foreach (exp_wr[i]) if (i < wr_got.size()) begin
      total++;
      if (wr_got[i] !== exp_wr[i]) begin bad++; $display("FAIL same_row_wr%0d: got %h want %h", i, wr_got[i], exp_wr[i]); end
    end
    total++;
    if (rd_got.size() != 1 || rd_got[0] !== {4'd3, 3'd3, 32'h00A3A2A1}) begin
      bad++; $display("FAIL same_row_rd: got n=%0d first=%h want row3 n3 00a3a2a1", rd_got.size(), rd_got.size() ? rd_got[0] : '0);
    end
  endtask

  task automatic test_overflow();
    bit ok;
    start_event();
    for (int i = 0; i < 5; i++) add_hit(7, 8'($urandom));
    send_hits(0);
    @(negedge clk);
    total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_set: got %b want 1", overflow); end
    total++; if (wr_got.size() != 4) begin bad++; $display("FAIL ovf_nwr: got %0d want 4", wr_got.size()); end
    do_flush(); m_readout();
    wait_done(300, ok);
    total++; if (!ok) begin bad++; $display("FAIL ovf_done: timeout, want done"); end
    total++;
    if (rd_got.size() != 1 || rd_got[0] !== exp_rd[0]) begin
      bad++; $display("FAIL ovf_rd: got n=%0d first=%h want %h", rd_got.size(), rd_got.size() ? rd_got[0] : '0, exp_rd[0]);
    end
    @(negedge clk);
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL ovf_clear: got %b want 0", overflow); end
  endtask

  task automatic test_sparse();
    bit ok;
    start_event();
    add_hit(0, 8'($urandom)); add_hit(15, 8'($urandom)); add_hit(5, 8'($urandom));
    send_hits(1);
    do_flush();
    m_readout();
    wait_done(300, ok);
    total++; if (!ok) begin bad++; $display("FAIL sparse_done: timeout, want done"); end
    total++; if (rr_cnt != 3) begin bad++; $display("FAIL sparse_nread: got %0d want 3", rr_cnt); end
    total++; if (rd_got.size() != 3) begin bad++; $display("FAIL sparse_nbeat: got %0d want 3", rd_got.size()); end
    foreach (exp_rd[i]) if (i < rd_got.size()) begin
      total++;
      if (rd_got[i] !== exp_rd[i]) begin bad++; $display("FAIL sparse_rd%0d: got %h want %h", i, rd_got[i], exp_rd[i]); end
    end
    start_event();
    do_flush();
    wait_done(300, ok);
    total++;
    if (!ok || rd_got.size() != 0 || rr_cnt != 0) begin
      bad++; $display("FAIL empty_event: done=%b beats=%0d reads=%0d want 1/0/0", ok, rd_got.size(), rr_cnt);
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    start_event();
    rd_mode = 0; tick(1);
    for (int r = 0; r < 16; r++) add_hit(r, 8'($urandom));
    send_hits(0); do_flush(); m_readout();
    tick(80);
    total++; if (rr_cnt != 8) begin bad++; $display("FAIL bp_stall_reads: got %0d want 8", rr_cnt); end
    total++;
    if (rd_got.size() != 0 || rd_valid !== 1'b1) begin
      bad++; $display("FAIL bp_stall_out: beats=%0d rd_valid=%b want 0/1", rd_got.size(), rd_valid);
    end
    rd_mode = 2;
    wait_done(600, ok);
    rd_mode = 1;
    total++; if (!ok) begin bad++; $display("FAIL bp_done: timeout, want done"); end
    total++; if (rd_got.size() != 16) begin bad++; $display("FAIL bp_nbeat: got %0d want 16", rd_got.size()); end
    foreach (exp_rd[i]) if (i < rd_got.size()) begin
      total++;
      if (rd_got[i] !== exp_rd[i]) begin bad++; $display("FAIL bp_rd%0d: got %h want %h", i, rd_got[i], exp_rd[i]); end
    end
  endtask

  task automatic test_stale();
    bit ok;
    start_event();
    for (int i = 0; i < 4; i++) add_hit(2, 8'($urandom));
    send_hits(0); do_flush();
    wait_done(300, ok);
    start_event();
    add_hit(2, 8'h55);
    send_hits(0); do_flush(); m_readout();
    wait_done(300, ok);
    total++; if (!ok) begin bad++; $display("FAIL stale_done: timeout, want done"); end
    total++;
    if (rd_got.size() != 1 || rd_got[0] !== exp_rd[0] || rd_got[0].data !== 32'h00000055) begin
      bad++; $display("FAIL stale_rd: got n=%0d first=%h want row2 n1 00000055", rd_got.size(), rd_got.size() ? rd_got[0] : '0);
    end
  endtask

  task automatic test_mid_reset();
    bit ok;
    int d0;
    start_event();
    rd_mode = 0; tick(1);
    for (int r = 0; r < 16; r++) add_hit(r, 8'($urandom));
    send_hits(0); do_flush();
    for (int c = 0; c < 200 && rr_cnt < 8; c++) tick(1);
    total++; if (rr_cnt < 8) begin bad++; $display("FAIL mr_reach_scan: reads=%0d want 8", rr_cnt); end
    d0 = done_cnt;
    reset = 1'b1;
    @(posedge clk); @(negedge clk);
    total++;
    if ({writeRow, readRow, rd_valid, done, overflow, rd_row, rd_nhits, rd_data} !== '0) begin
      bad++; $display("FAIL mr_outputs: wr=%b rr=%b rv=%b dn=%b ov=%b want all 0", writeRow, readRow, rd_valid, done, overflow);
    end
    tick(1); reset = 1'b0;
    rd_got.delete(); rd_mode = 1;
    tick(30);
    total++;
    if (done_cnt != d0 || rd_got.size() != 0) begin
      bad++; $display("FAIL mr_quiet: dones=%0d beats=%0d want 0/0", done_cnt - d0, rd_got.size());
    end
    start_event();
    add_hit(9, 8'($urandom));
    send_hits(0); do_flush(); m_readout();
    wait_done(300, ok);
    total++;
    if (!ok || rd_got.size() != 1 || rd_got[0] !== exp_rd[0]) begin
      bad++; $display("FAIL mr_new_event: done=%b n=%0d first=%h want %h", ok, rd_got.size(), rd_got.size() ? rd_got[0] : '0, exp_rd[0]);
    end
  endtask

  task automatic test_random();
    bit ok;
    int nh, span, hold;
    for (int ev = 0; ev < 5; ev++) begin
      start_event();
      nh = $urandom_range(0, 20);
      span = ($urandom_range(0, 1) != 0) ? 3 : 15;
      for (int i = 0; i < nh; i++) add_hit($urandom_range(0, span), 8'($urandom));
      send_hits(bit'($urandom_range(0, 1)));
      @(negedge clk);
      total++; if (overflow !== m_ovf) begin bad++; $display("FAIL rnd%0d_ovf: got %b want %b", ev, overflow, m_ovf); end
      him_ready = 1'b0;
      if (nh == 0) do_flush(); else do_flush();
      m_readout();
      rd_mode = 2;
      hold = $urandom_range(8, 20);
      tick(hold);
      total++; if (rr_cnt != 0) begin bad++; $display("FAIL rnd%0d_hold: reads=%0d want 0 while him_ready=0", ev, rr_cnt); end
      him_ready = 1'b1;
      wait_done(600, ok);
      total++; if (!ok) begin bad++; $display("FAIL rnd%0d_done: timeout, want done", ev); end
      total++;
      if (wr_got.size() != exp_wr.size() || rd_got.size() != exp_rd.size()) begin
        bad++; $display("FAIL rnd%0d_sizes: wr=%0d rd=%0d want %0d/%0d", ev, wr_got.size(), rd_got.size(), exp_wr.size(), exp_rd.size());
      end
      foreach (exp_wr[i]) if (i < wr_got.size()) begin
        total++;
        if (wr_got[i] !== exp_wr[i]) begin bad++; $display("FAIL rnd%0d_wr%0d: got %h want %h", ev, i, wr_got[i], exp_wr[i]); end
      end
      foreach (exp_rd[i]) if (i < rd_got.size()) begin
        total++;
        if (rd_got[i] !== exp_rd[i]) begin bad++; $display("FAIL rnd%0d_rd%0d: got %h want %h", ev, i, rd_got[i], exp_rd[i]); end
      end
      rd_mode = 1;
    end
  endtask

  initial begin
    for (int r = 0; r < 16; r++) mem[r] = $urandom;
    for (int i = 0; i < 4; i++) dl[i] = '0;
    test_reset();
    test_same_row();
    test_overflow();
    test_sparse();
    test_backpressure();
    test_stale();
    test_mid_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
